// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch unit: one outstanding memory read, one-entry skid buffer, redirect flush
// Bit numbering in the interface is MSB-first, so "bits 30-31" of redirect_pc are the two LSBs here.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h80020000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_rd_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rd_ack,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        valid_insn
);

    typedef enum logic [1:0] {START, REQ, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_insn_q, buf_insn_d;
    logic [31:0] buf_pc_q, buf_pc_d;

    logic [31:0] redir_tgt;
    logic [31:0] req_addr_inc;
    logic        out_free;

    assign redir_tgt    = redirect_pc & 32'hFFFF_FFFC;
    assign req_addr_inc = req_addr_q + 32'd4;
    assign out_free     = !valid_q || !stall;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        insn_d     = insn_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        buf_insn_d = buf_insn_q;
        buf_pc_d   = buf_pc_q;

        // A presented instruction leaves on any edge the consumer accepts it.
        if (valid_q && !stall) begin
            valid_d = 1'b0;
        end

        case (state_q)
            START: begin
                state_d = REQ;
                if (redirect) begin
                    fetch_pc_d = redir_tgt;
                    req_addr_d = redir_tgt;
                end else begin
                    req_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redir_tgt;
                    if (mem_rd_ack) begin
                        req_addr_d = redir_tgt;
                    end else begin
                        state_d = DROP;
                    end
                end else if (mem_rd_ack) begin
                    fetch_pc_d = req_addr_inc;
                    req_addr_d = req_addr_inc;
                    if (out_free) begin
                        insn_d  = mem_rd_data;
                        pc_d    = req_addr_q;
                        valid_d = 1'b1;
                    end else begin
                        buf_insn_d = mem_rd_data;
                        buf_pc_d   = req_addr_q;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    fetch_pc_d = redir_tgt;
                    req_addr_d = redir_tgt;
                    state_d    = REQ;
                end else if (!stall) begin
                    insn_d     = buf_insn_q;
                    pc_d       = buf_pc_q;
                    valid_d    = 1'b1;
                    req_addr_d = fetch_pc_q;
                    state_d    = REQ;
                end
            end
            DROP: begin
                // The old read must complete before the new target is requested.
                if (redirect) begin
                    fetch_pc_d = redir_tgt;
                end
                if (mem_rd_ack) begin
                    req_addr_d = redirect ? redir_tgt : fetch_pc_q;
                    state_d    = REQ;
                end
            end
            default: state_d = START;
        endcase

        if (redirect) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= START;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            insn_q     <= 32'h0;
            pc_q       <= 32'h0;
            valid_q    <= 1'b0;
            buf_insn_q <= 32'h0;
            buf_pc_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            insn_q     <= insn_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            buf_insn_q <= buf_insn_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

    assign mem_rd_req = (state_q == REQ) || (state_q == DROP);
    assign mem_addr   = req_addr_q;
    assign insn       = insn_q;
    assign pc         = pc_q;
    assign valid_insn = valid_q;

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for fetch: vector table, directed corner cases, scoreboard
module tb_fetch;

    localparam logic [31:0] RST_PC  = 32'h80020000;
    localparam logic [31:0] RST_PC2 = 32'hFFFFFFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_rd_ack = 1'b0;
    logic [31:0] mem_rd_data;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        valid_insn;

    logic [31:0] mem_rd_data2;
    logic        mem_rd_req2;
    logic [31:0] mem_addr2;
    logic [31:0] insn2;
    logic [31:0] pc2;
    logic        valid_insn2;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a[7:0] == 8'h0C) return 32'h0;
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    assign mem_rd_data  = memf(mem_addr);
    assign mem_rd_data2 = memf(mem_addr2);

    fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .insn(insn),
        .pc(pc), .valid_insn(valid_insn)
    );

    fetch #(.RESET_PC(RST_PC2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .mem_rd_req(mem_rd_req2), .mem_addr(mem_addr2),
        .mem_rd_ack(1'b1), .mem_rd_data(mem_rd_data2), .insn(insn2),
        .pc(pc2), .valid_insn(valid_insn2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected deliveries pushed at each accepted memory return.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } item_t;
    item_t sb[$];

    logic        mon_en = 1'b0;
    logic [31:0] exp_req, exp_fetch;
    logic        dropping;
    logic        prev_req, prev_ack, prev_redir, prev_valid, prev_stall;
    logic [31:0] prev_addr, prev_pc, prev_insn;

    task automatic model_reset();
        sb.delete();
        exp_req    = RST_PC;
        exp_fetch  = RST_PC;
        dropping   = 1'b0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_redir = 1'b0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        prev_addr  = 32'h0;
        prev_pc    = 32'h0;
        prev_insn  = 32'h0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            item_t       it;
            logic [31:0] tgt;
            tgt = redirect_pc & 32'hFFFF_FFFC;
            if (prev_req && !prev_ack) begin
                chk("req_held", mem_rd_req, 1);
                chk("addr_held", mem_addr, prev_addr);
            end
            if (prev_redir) begin
                chk("flush_valid", valid_insn, 0);
            end else if (prev_valid && prev_stall) begin
                chk("stall_valid", valid_insn, 1);
                chk("stall_pc", pc, prev_pc);
                chk("stall_insn", insn, prev_insn);
            end
            if (valid_insn && !stall && !redirect) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: delivered pc %h insn %h, expected nothing at %0t", pc, insn, $time);
                end else begin
                    it = sb.pop_front();
                    chk("sb_pc", pc, it.a);
                    chk("sb_insn", insn, it.d);
                    n_pop++;
                end
            end
            if (redirect) sb.delete();
            if (mem_rd_req && mem_rd_ack) begin
                chk("ack_addr", mem_addr, exp_req);
                if (redirect) begin
                    exp_req   = tgt;
                    exp_fetch = tgt;
                    dropping  = 1'b0;
                end else if (dropping) begin
                    exp_req  = exp_fetch;
                    dropping = 1'b0;
                end else begin
                    sb.push_back('{exp_req, memf(exp_req)});
                    exp_req   = exp_req + 32'd4;
                    exp_fetch = exp_req;
                end
            end else if (redirect) begin
                exp_fetch = tgt;
                if (mem_rd_req) dropping = 1'b1;
                else exp_req = tgt;
            end
            prev_req   = mem_rd_req;
            prev_ack   = mem_rd_ack;
            prev_redir = redirect;
            prev_valid = valid_insn;
            prev_stall = stall;
            prev_addr  = mem_addr;
            prev_pc    = pc;
            prev_insn  = insn;
        end
    end

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] addr2;
    } vec_t;
    vec_t vt[6];

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, RST_PC,        1'b0, 32'h0,        32'h0,               32'hFFFFFFF8};
        vt[1] = '{1'b1, 32'h80020000,  1'b0, 32'h0,        32'h0,               32'hFFFFFFF8};
        vt[2] = '{1'b1, 32'h80020004,  1'b1, 32'h80020000, memf(32'h80020000),  32'hFFFFFFFC};
        vt[3] = '{1'b1, 32'h80020008,  1'b1, 32'h80020004, memf(32'h80020004),  32'h00000000};
        vt[4] = '{1'b1, 32'h8002000C,  1'b1, 32'h80020008, memf(32'h80020008),  32'h00000004};
        vt[5] = '{1'b1, 32'h80020010,  1'b1, 32'h8002000C, 32'h0,               32'h00000008};

        model_reset();
        #12;
        chk("rst_req", mem_rd_req, 0);
        chk("rst_addr", mem_addr, RST_PC);
        chk("rst_valid", valid_insn, 0);
        chk("rst_insn", insn, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr2", mem_addr2, RST_PC2);
        mem_rd_ack = 1'b1;
        #6;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        #1;

        // Ack tied high from reset release.
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #2;
            end
            chk($sformatf("vec%0d_req", i), mem_rd_req, vt[i].req);
            chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].addr);
            chk($sformatf("vec%0d_valid", i), valid_insn, vt[i].valid);
            chk($sformatf("vec%0d_pc", i), pc, vt[i].pc);
            chk($sformatf("vec%0d_insn", i), insn, vt[i].insn);
            chk($sformatf("vec%0d_addr2", i), mem_addr2, vt[i].addr2);
        end

        // Three stalled cycles while memory keeps acking.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("hold_req", mem_rd_req, 0);
            chk("hold_pc", pc, 32'h8002000C);
            chk("hold_valid", valid_insn, 1);
        end
        stall = 1'b0;
        tick();
        #1;
        chk("unhold_pc", pc, 32'h80020010);
        chk("unhold_insn", insn, memf(32'h80020010));
        chk("unhold_req", mem_rd_req, 1);
        chk("unhold_addr", mem_addr, 32'h80020014);
        tick();
        #1;
        chk("unhold_pc2", pc, 32'h80020014);

        // Asynchronous reset while in HOLD.
        stall = 1'b1;
        tick();
        #1;
        chk("hold2_req", mem_rd_req, 0);
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("arst_req", mem_rd_req, 0);
        chk("arst_addr", mem_addr, RST_PC);
        chk("arst_valid", valid_insn, 0);
        chk("arst_insn", insn, 0);
        chk("arst_pc", pc, 0);
        chk("arst_addr2", mem_addr2, RST_PC2);
        stall = 1'b0;
        repeat (2) tick();
        #1;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Redirect while the read at 80020008 is outstanding.
        tick();
        tick();
        tick();
        chk("pre_redir_addr", mem_addr, 32'h80020008);
        chk("pre_redir_pc", pc, 32'h80020004);
        mem_rd_ack  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h00400013;
        tick();
        redirect = 1'b0;
        #1;
        chk("drop_req", mem_rd_req, 1);
        chk("drop_addr", mem_addr, 32'h80020008);
        chk("drop_valid", valid_insn, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            chk("drop_wait_addr", mem_addr, 32'h80020008);
            chk("drop_wait_valid", valid_insn, 0);
        end
        mem_rd_ack = 1'b1;
        tick();
        #1;
        chk("post_drop_addr", mem_addr, 32'h00400010);
        chk("post_drop_valid", valid_insn, 0);
        tick();
        #1;
        chk("post_drop_pc", pc, 32'h00400010);
        chk("post_drop_vld", valid_insn, 1);

        // Redirect, stall and ack together.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h00001000;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        #1;
        chk("tri_valid", valid_insn, 0);
        chk("tri_addr", mem_addr, 32'h00001000);
        tick();
        #1;
        chk("tri_pc", pc, 32'h00001000);

        // Random traffic, checked by the scoreboard and protocol monitor.
        for (int k = 0; k < 400; k++) begin
            tick();
            mem_rd_ack  = ($urandom_range(0, 99) < 60);
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15)) : $urandom;
        end
        tick();
        redirect   = 1'b0;
        stall      = 1'b0;
        mem_rd_ack = 1'b1;
        repeat (20) tick();

        n_cmp++;
        if (n_pop < 40) begin
            n_bad++;
            $display("FAIL delivered_count: got %0d expected at least 40", n_pop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80020000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, meaning the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port stall, input, 1, meaning the consumer does not accept the presented instruction this cycle.
REQ-005 SHALL have port redirect, input, 1, meaning a one-cycle flush with a new fetch target.
REQ-006 SHALL have port redirect_pc, input, 32, meaning the new fetch target, sampled when redirect=1.
REQ-007 SHALL have port mem_rd_req, output, 1, meaning an instruction memory read request.
REQ-008 SHALL have port mem_addr, output, 32, meaning the byte address of the outstanding read.
REQ-009 SHALL have port mem_rd_ack, input, 1, meaning mem_rd_data is valid and the request completes at this edge.
REQ-010 SHALL have port mem_rd_data, input, 32, meaning the instruction word, bit 0 = MSB.
REQ-011 SHALL have port insn, output, 32, meaning the presented instruction, bit 0 = MSB, opcode in bits 0-5.
REQ-012 SHALL have port pc, output, 32, meaning the address of insn.
REQ-013 SHALL have port valid_insn, output, 1, meaning insn/pc hold a deliverable instruction.

Function
REQ-014 SHALL implement states START, REQ, HOLD and DROP, all registered.
REQ-015 SHALL drive mem_rd_req=1 exactly in REQ and DROP, and drive mem_addr from a dedicated request-address register.
REQ-016 SHALL keep mem_rd_req and mem_addr stable from request start until the edge with mem_rd_ack=1, with no abandonment.
REQ-017 SHALL define a transfer as a rising edge with valid_insn=1 and stall=0.
REQ-018 SHALL hold insn, pc and valid_insn unchanged while valid_insn=1 and stall=1, redirect excepted.
REQ-019 SHALL transition START->REQ on the first edge after reset release, with request address = fetch_pc.
REQ-020 SHALL, in REQ with mem_rd_ack=1 and the output free (valid_insn=0 or stall=0), load insn<=mem_rd_data and pc<=request address, set valid_insn=1, advance fetch_pc, and stay in REQ with the new address.
REQ-021 SHALL, in REQ with mem_rd_ack=1 and the output occupied with stall=1, place the word and address into a one-entry buffer, advance fetch_pc, and go to HOLD.
REQ-022 SHALL, in HOLD, keep mem_rd_req=0, and on the first edge with stall=0 move the buffer into insn/pc with valid_insn=1 and go to REQ.
REQ-023 SHALL advance fetch_pc by 4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
REQ-024 SHALL, on an edge with redirect=1, clear valid_insn, discard the buffer, and set fetch_pc to redirect_pc with bits 30-31 forced to 0; redirect has priority over stall and ack.
REQ-025 SHALL, on redirect in REQ with mem_rd_ack=1, discard the acked word and stay in REQ at the new fetch_pc.
REQ-026 SHALL, on redirect in REQ with mem_rd_ack=0, go to DROP.
REQ-027 SHALL, in DROP, keep the old request until ack, discard the returned word, then go to REQ at fetch_pc.
REQ-028 SHALL, on a further redirect in DROP, update fetch_pc only.
REQ-029 SHALL, on redirect in HOLD or START, go to REQ at the redirect target.
REQ-030 SHALL deliver instructions in address order, each exactly once, and pass insn=32'h00000000 through unchanged.
REQ-031 SHALL have minimum latency from ack edge N to valid_insn=1 of edge N, and sustain one instruction per cycle with zero-wait memory and stall=0.

Reset
REQ-032 SHALL, while rst_n=0, force state=START, fetch_pc=RESET_PC, mem_addr=RESET_PC, mem_rd_req=0, valid_insn=0, insn=0, pc=0, buffer empty.
REQ-033 SHALL apply reset immediately on the rst_n falling edge, independent of clk, including mid-request; any in-flight ack after release is ignored because the state is START.

Verification
REQ-034 Reset release with ack tied high -> mem_addr 80020000, 80020004, 80020008 on consecutive cycles; pc follows one cycle later with valid_insn held at 1.
REQ-035 stall=1 for 3 cycles while ack arrives -> valid instruction held, next word buffered, mem_rd_req=0 in HOLD; on stall=0 words delivered in order with no loss or duplication.
REQ-036 redirect to 32'h00400013 with a pending unacked request at 80020008 -> mem_addr held at 80020008 until ack, word discarded, next mem_addr 00400010, valid_insn=0 meanwhile.
REQ-037 RESET_PC=32'hFFFFFFF8 with ack tied high -> fetches FFFFFFF8, FFFFFFFC, 00000000.
REQ-038 rst_n asserted mid-wait while in HOLD -> outputs reach reset values without a clock edge; after release fetching restarts at RESET_PC.
REQ-039 redirect, stall and ack asserted in the same cycle -> redirect wins, acked word dropped, valid_insn=0 on the next cycle.
